// File: rtl/replicate_pkg.sv
// Shared definitions for the replicate_seq block: FSM state encoding and
// the ceiling-log2 helper used to size count fields.
package replicate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Number of bits needed to hold values 0 .. v-1 (minimum 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/replicate_acc.sv
// Shift-accumulate datapath: each shift pushes one element into the low end,
// older copies move up; clear empties the register before a new result.
module replicate_acc #(
  parameter int W  = 8,
  parameter int OW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          shift,
  input  logic [W-1:0]  element,
  output logic [OW-1:0] acc
);

  logic [OW-1:0] elem_ext;

  always_comb begin
    elem_ext = '0;
    elem_ext[W-1:0] = element;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (shift) begin
      acc <= (acc << W) | elem_ext;
    end
  end

endmodule

// File: rtl/replicate_seq.sv
// Replicates one W-bit element n times (n saturated to MAX_REP) into a
// zero-extended OW-bit result, one copy per cycle, with valid/ready on both sides.
module replicate_seq
  import replicate_pkg::*;
#(
  parameter int W       = 8,
  parameter int MAX_REP = 4,
  localparam int CW     = clog2(MAX_REP + 1),
  localparam int OW     = W * MAX_REP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [CW-1:0] in_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic [CW-1:0] out_count,
  output logic          out_sat,
  output state_t        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in HOLD; the requester
  // keeps in_valid/in_data/in_count stable until it sees the transfer.

  localparam logic [CW-1:0] MAX_C = CW'(MAX_REP);

  state_t        state;
  logic [W-1:0]  element;
  logic [CW-1:0] remaining;
  logic [CW-1:0] eff_count;
  logic          accept;
  logic          shift;

  assign accept    = (state == IDLE) && in_valid;
  assign shift     = (state == BUILD);
  assign eff_count = (in_count > MAX_C) ? MAX_C : in_count;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      element   <= '0;
      remaining <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            element   <= in_data;
            out_count <= eff_count;
            out_sat   <= (in_count > MAX_C);
            remaining <= eff_count;
            state     <= (eff_count == '0) ? HOLD : BUILD;
          end
        end
        BUILD: begin
          remaining <= remaining - CW'(1);
          if (remaining == CW'(1)) state <= HOLD;
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The accept edge clears the accumulator; BUILD edges append the latched copy.
  replicate_acc #(
    .W  (W),
    .OW (OW)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .shift   (shift),
    .element (element),
    .acc     (out_data)
  );

endmodule

// File: tb/tb_replicate_seq.sv
// Directed bench for replicate_seq (W=8, MAX_REP=4): reset, replication,
// saturation, HOLD stability, back-to-back handshake and mid-build reset.
module tb_replicate_seq;
  import replicate_pkg::*;

  localparam int W = 8;
  localparam int MAX_REP = 4;
  localparam int CW = 3;
  localparam int OW = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [CW-1:0] in_count;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_sat;
  state_t        dbg_state;

  int checks;
  int failures;

  replicate_seq #(.W(W), .MAX_REP(MAX_REP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_sat   (out_sat),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h77; in_count = 3'd2; out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h want=00000000", out_data); end
    checks++;
    if (out_count !== 3'd0 || out_sat !== 1'b0) begin
      failures++; $display("FAIL reset_count_sat got=%0d/%b want=0/0", out_count, out_sat);
    end
    checks++;
    if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_no_accept got=%b want=1", in_ready); end
  endtask

  // One full request: accept, measure latency, check result, drain.
  task automatic test_replicate(input string name, input logic [W-1:0] data,
                                input logic [CW-1:0] count, input logic [OW-1:0] exp_data,
                                input logic [CW-1:0] exp_count, input logic exp_sat,
                                input int exp_lat);
    int lat;
    in_valid = 1'b1; in_data = data; in_count = count; out_ready = 1'b0;
    tick();
    // Scramble the request inputs; the result in progress must ignore them.
    in_valid = 1'b0; in_data = ~data; in_count = 3'd1;
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin failures++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat); end
    checks++;
    if (out_data !== exp_data) begin failures++; $display("FAIL %s_data got=%h want=%h", name, out_data, exp_data); end
    checks++;
    if (out_count !== exp_count) begin failures++; $display("FAIL %s_count got=%0d want=%0d", name, out_count, exp_count); end
    checks++;
    if (out_sat !== exp_sat) begin failures++; $display("FAIL %s_sat got=%b want=%b", name, out_sat, exp_sat); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL %s_drain got in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_hold_stable();
    in_valid = 1'b1; in_data = 8'h5A; in_count = 3'd2; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL hold_build_flags got in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      in_data  = 8'h10 + 8'(i);
      in_count = 3'(i + 1);
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++; $display("FAIL hold_flags cyc=%0d got out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready);
      end
      checks++;
      if (out_data !== 32'h00005A5A || out_count !== 3'd2) begin
        failures++; $display("FAIL hold_data cyc=%0d got=%h/%0d want=00005a5a/2", i, out_data, out_count);
      end
    end
    // Pop with a new request already waiting: the pop edge must not accept it.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11; in_count = 3'd1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL pop_to_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    out_ready = 1'b0;
    tick();
    checks++;
    if (dbg_state !== BUILD) begin failures++; $display("FAIL b2b_accept got=%0d want=%0d", dbg_state, BUILD); end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00000011 || out_count !== 3'd1) begin
      failures++; $display("FAIL b2b_result got v=%b d=%h c=%0d want 1/00000011/1", out_valid, out_data, out_count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_build();
    in_valid = 1'b1; in_data = 8'hC3; in_count = 3'd4; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (out_data !== 32'h0000C3C3) begin failures++; $display("FAIL midbuild_partial got=%h want=0000c3c3", out_data); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL midbuild_reset_flags got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_data !== 32'h0 || out_count !== 3'd0 || out_sat !== 1'b0) begin
      failures++; $display("FAIL midbuild_reset_regs got d=%h c=%0d s=%b want 0/0/0", out_data, out_count, out_sat);
    end
    test_replicate("after_reset", 8'h01, 3'd2, 32'h00000101, 3'd2, 1'b0, 2);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_count = '0; out_ready = 1'b0;
    test_reset();
    test_replicate("full_a5",  8'hA5, 3'd4, 32'hA5A5A5A5, 3'd4, 1'b0, 4);
    test_replicate("one_3c",   8'h3C, 3'd1, 32'h0000003C, 3'd1, 1'b0, 1);
    test_replicate("zero",     8'h3C, 3'd0, 32'h00000000, 3'd0, 1'b0, 0);
    test_replicate("sat_ff",   8'hFF, 3'd7, 32'hFFFFFFFF, 3'd4, 1'b1, 4);
    test_replicate("three_81", 8'h81, 3'd3, 32'h00818181, 3'd3, 1'b0, 3);
    test_replicate("sat5_12",  8'h12, 3'd5, 32'h12121212, 3'd4, 1'b1, 4);
    test_hold_stable();
    test_reset_mid_build();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/replicate_seq.md
REPLICATE_SEQ -- requirements
Module: replicate_seq

Interface
REQ-001 Parameter W, default 8, width of one replicated element; W >= 1.
REQ-002 Parameter MAX_REP, default 4, maximum replication count; MAX_REP >= 1.
REQ-003 Derived constant CW = clog2(MAX_REP+1), width of count fields; OW = W*MAX_REP, output width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 in_data  input  W  element to replicate.
REQ-009 in_count  input  CW  requested replication count n.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 out_data  output  OW  result {n{in_data}} zero-extended to OW.
REQ-013 out_count  output  CW  effective (saturated) count used.
REQ-014 out_sat  output  1  in_count exceeded MAX_REP.

Function
REQ-015 The block SHALL have three states: IDLE, BUILD, HOLD.
REQ-016 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is HOLD.
REQ-017 Accept: in_valid && in_ready at a rising edge latches in_data, the effective count n = min(in_count, MAX_REP), out_sat = (in_count > MAX_REP), and clears the accumulator to 0.
REQ-018 On accept with n = 0 the state SHALL go to HOLD directly; out_data = 0, out_count = 0.
REQ-019 On accept with n > 0 the state SHALL go to BUILD with remaining = n.
REQ-020 Each BUILD edge SHALL set acc = (acc << W) | element, truncated to OW bits, and decrement remaining; the edge that brings remaining to 0 SHALL move to HOLD.
REQ-021 Latency: out_valid SHALL rise n rising edges after the accept edge; for n = 0, on the accept edge itself.
REQ-022 In HOLD, out_data, out_count and out_sat SHALL stay stable until out_ready = 1.
REQ-023 An edge in HOLD with out_ready = 1 SHALL move to IDLE; no new request is accepted on that same edge.
REQ-024 In HOLD, bits of out_data above n*W SHALL be 0; bits [n*W-1:0] SHALL equal n copies of the latched element.
REQ-025 in_data and in_count changes after acceptance SHALL not affect the result in progress.
REQ-026 in_valid while not IDLE SHALL be ignored; the requester holds it (valid/ready rule).
REQ-027 out_data SHALL be directly usable as a constant-foldable width: OW is an elaboration-time constant.

Reset
REQ-028 rst_n = 0 at a rising edge SHALL force IDLE, acc = 0, remaining = 0, out_count = 0, out_sat = 0, from any state including mid-BUILD.
REQ-029 After reset: in_ready = 1, out_valid = 0, out_data = 0.
REQ-030 A request presented on the reset edge SHALL NOT be accepted.

Structure
REQ-031 Package replicate_pkg SHALL hold the state encoding (IDLE, BUILD, HOLD) and the clog2 helper used for CW.
REQ-032 The shift-accumulate datapath (acc register, shift-or update, clear) SHALL be sub-module replicate_acc, parametrised by W and OW; the FSM, counter and handshake stay in replicate_seq.

Verification (W=8, MAX_REP=4)
REQ-033 in_data=8'hA5, in_count=4, out_ready=1 -> out_valid 4 edges after accept, out_data=32'hA5A5A5A5, out_count=4, out_sat=0.
REQ-034 in_data=8'h3C, in_count=1 -> out_data=32'h0000003C after 1 edge; in_count=0 -> out_valid on accept edge, out_data=0, out_count=0.
REQ-035 in_data=8'hFF, in_count=7 -> out_data=32'hFFFFFFFF, out_count=4, out_sat=1.
REQ-036 Result 32'h5A5A in HOLD, out_ready low 3 cycles while in_data/in_valid toggle -> out_data, out_count unchanged, in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-037 rst_n=0 for one edge during BUILD (2 of 4 copies done) -> IDLE next cycle, out_valid=0, out_data=0; next request 8'h01 count 2 -> 32'h00000101.
REQ-038 Property: whenever out_valid, out_data == (element replicated out_count times, zero-extended); checked formally for W=2, MAX_REP=3.
